// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter with a one-entry holding register and a running
// 32-bit sum of every byte whose frame has fully completed.
module uart_tx #(
  parameter int cycles_per_bit = 4,
  parameter int stop_bits      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_data,
  input  logic        i_req,
  output logic        o_serial,
  output logic        o_cts,
  output logic        o_idle,
  output logic [31:0] o_sum
);

  localparam int CW = $clog2(cycles_per_bit);
  localparam logic [CW-1:0] CYC_LAST = CW'(cycles_per_bit - 1);
  localparam logic STOP_LAST = 1'(stop_bits - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          stop_q, stop_d;
  logic [31:0]   sum_q, sum_d;

  logic accept;
  logic bit_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      cyc_q       <= '0;
      stop_q      <= 1'b0;
      sum_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      cyc_q       <= cyc_d;
      stop_q      <= stop_d;
      sum_q       <= sum_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    cyc_d       = cyc_q;
    stop_d      = stop_q;
    sum_d       = sum_q;

    accept  = i_req && !hold_full_q;
    bit_end = (cyc_q == '0);

    // Accept and drain are mutually exclusive: draining needs hold_full, accepting needs it clear.
    if (accept) begin
      hold_d      = i_data;
      hold_full_d = 1'b1;
    end

    if (state_q != IDLE) begin
      cyc_d = cyc_q - CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          state_d     = START;
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          cyc_d       = CYC_LAST;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = 3'd7;
          cyc_d     = CYC_LAST;
        end
      end
      DATA: begin
        if (bit_end) begin
          // Rotating rather than shifting leaves the byte intact for the sum after eight bits.
          shift_d = {shift_q[0], shift_q[7:1]};
          cyc_d   = CYC_LAST;
          if (bit_cnt_q == 3'd0) begin
            state_d = STOP;
            stop_d  = STOP_LAST;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_q) begin
            stop_d = 1'b0;
            cyc_d  = CYC_LAST;
          end else begin
            sum_d = sum_q + {24'b0, shift_q};
            if (hold_full_q) begin
              state_d     = START;
              shift_d     = hold_q;
              hold_full_d = 1'b0;
              cyc_d       = CYC_LAST;
            end else begin
              state_d = IDLE;
              cyc_d   = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_serial = 1'b1;
    case (state_q)
      START:   o_serial = 1'b0;
      DATA:    o_serial = shift_q[0];
      default: o_serial = 1'b1;
    endcase
  end

  assign o_cts  = !hold_full_q;
  assign o_idle = (state_q == IDLE) && !hold_full_q;
  assign o_sum  = sum_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (4 clk/bit 1 stop, 7 clk/bit 2 stop) checked
// every cycle against a frame-level model, plus hand-computed pins.
module tb_uart_tx;

  localparam int CPB0 = 4;
  localparam int SB0  = 1;
  localparam int CPB1 = 7;
  localparam int SB1  = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0  = 1'b0;
  logic        req1  = 1'b0;
  logic [7:0]  data0 = '0;
  logic [7:0]  data1 = '0;
  logic        serial0, cts0, idle0;
  logic        serial1, cts1, idle1;
  logic [31:0] sum0, sum1;

  int errors = 0;
  int checks = 0;

  uart_tx #(.cycles_per_bit(CPB0), .stop_bits(SB0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_data(data0), .i_req(req0),
    .o_serial(serial0), .o_cts(cts0), .o_idle(idle0), .o_sum(sum0)
  );

  uart_tx #(.cycles_per_bit(CPB1), .stop_bits(SB1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_data(data1), .i_req(req1),
    .o_serial(serial1), .o_cts(cts1), .o_idle(idle1), .o_sum(sum1)
  );

  always #5 clk = ~clk;

  // Frame-level model: a frame is a word of bits, each held for cpb clocks.
  typedef struct {
    bit          active;
    int          pos;
    logic [10:0] word;
    logic [7:0]  cur;
    bit          hFull;
    logic [7:0]  hByte;
    logic [31:0] sum;
  } mstate_t;

  mstate_t m0, m1;

  function automatic mstate_t modelReset();
    mstate_t s;
    s.active = 1'b0;
    s.pos    = 0;
    s.word   = '0;
    s.cur    = '0;
    s.hFull  = 1'b0;
    s.hByte  = '0;
    s.sum    = '0;
    return s;
  endfunction

  function automatic mstate_t modelStep(mstate_t s, logic req, logic [7:0] d, int cpb, int sb);
    mstate_t n = s;
    bit acc = req && !s.hFull;
    if (n.active) begin
      n.pos++;
      if (n.pos == (9 + sb) * cpb) begin
        n.active = 1'b0;
        n.sum    = n.sum + 32'(n.cur);
      end
    end
    if (!n.active && n.hFull) begin
      n.active = 1'b1;
      n.pos    = 0;
      n.cur    = n.hByte;
      n.word   = {2'b11, n.hByte, 1'b0};
      n.hFull  = 1'b0;
    end
    if (acc) begin
      n.hFull = 1'b1;
      n.hByte = d;
    end
    return n;
  endfunction

  function automatic logic expSerial(mstate_t s, int cpb);
    if (!s.active) return 1'b1;
    return s.word[s.pos / cpb];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= modelReset();
      m1 <= modelReset();
    end else begin
      m0 <= modelStep(m0, req0, data0, CPB0, SB0);
      m1 <= modelStep(m1, req1, data1, CPB1, SB1);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("serial0", 32'(serial0), 32'(expSerial(m0, CPB0)));
    checkOutput("cts0",    32'(cts0),    32'(!m0.hFull));
    checkOutput("idle0",   32'(idle0),   32'(!m0.active && !m0.hFull));
    checkOutput("sum0",    sum0,         m0.sum);
    checkOutput("serial1", 32'(serial1), 32'(expSerial(m1, CPB1)));
    checkOutput("cts1",    32'(cts1),    32'(!m1.hFull));
    checkOutput("idle1",   32'(idle1),   32'(!m1.active && !m1.hFull));
    checkOutput("sum1",    sum1,         m1.sum);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input int which, input logic r, input logic [7:0] d);
    if (which == 0) begin
      req0  = r;
      data0 = d;
    end else begin
      req1  = r;
      data1 = d;
    end
  endtask

  task automatic waitIdle(input int which, input int bound);
    int n = 0;
    while (((which == 0) ? !idle0 : !idle1) && n < bound) begin
      tick();
      n++;
    end
    checkOutput(which == 0 ? "waitIdle0" : "waitIdle1",
                32'(which == 0 ? idle0 : idle1), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          k;
    int          n;
    int          accCount;
    bit          acc;
    logic [9:0]  pat;
    logic [31:0] accSum;

    tick();
    tick();
    rst_n = 1'b1;

    // Reset then idle: line high, ready, idle, zero sum.
    for (int c = 0; c < 100; c++) begin
      tick();
      checkOutput("rstIdleSerial", 32'(serial0), 32'd1);
      checkOutput("rstIdleCts",    32'(cts0),    32'd1);
      checkOutput("rstIdleIdle",   32'(idle0),   32'd1);
      checkOutput("rstIdleSum",    sum0,         32'd0);
    end

    // Single 0xA5 frame: start, LSB-first data, stop; sum lands one edge after.
    pat = 10'b1_1010_0101_0;
    applyStimulus(0, 1'b1, 8'hA5);
    tick();
    applyStimulus(0, 1'b0, 8'h00);
    for (int c = 0; c < 40; c++) begin
      tick();
      if (c % 4 == 1) checkOutput($sformatf("a5Bit%0d", c / 4), 32'(serial0), 32'(pat[c / 4]));
      if (c == 39) checkOutput("a5SumBefore", sum0, 32'd0);
    end
    tick();
    checkOutput("a5SumAfter", sum0, 32'h0000_00A5);
    checkOutput("a5IdleAfter", 32'(idle0), 32'd1);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Stream 1..16 with req held high: back-to-back, idle exactly 641 clocks after first accept.
    applyStimulus(0, 1'b1, 8'd1);
    k = 1;
    n = 0;
    while (k <= 16 && n < 2000) begin
      acc = cts0;
      tick();
      n++;
      if (acc) begin
        k++;
        data0 = 8'(k);
      end
    end
    req0 = 1'b0;
    while (!idle0 && n < 2000) begin
      tick();
      n++;
    end
    checkOutput("streamIdleAt", 32'(n), 32'd642);
    checkOutput("streamSum", sum0, 32'd136);

    // Data changes every cycle with req high: only bytes on accept edges are sent.
    accSum   = '0;
    accCount = 0;
    req0     = 1'b1;
    for (int c = 0; c < 100; c++) begin
      data0 = 8'(c * 37 + 11);
      if (cts0) begin
        accSum = accSum + 32'(data0);
        accCount++;
      end
      tick();
    end
    req0 = 1'b0;
    waitIdle(0, 400);
    checkOutput("ignoreCount", 32'(accCount), 32'd4);
    checkOutput("ignoreAccSum", accSum, 32'd354);
    checkOutput("ignoreSum", sum0, 32'd490);

    // Reset in the middle of data bit 3 of 0x5A with 0x77 pending.
    applyStimulus(0, 1'b1, 8'h5A);
    tick();
    data0 = 8'h77;
    tick();
    tick();
    req0 = 1'b0;
    repeat (16) tick();
    checkOutput("preResetSerial", 32'(serial0), 32'd1);
    checkOutput("preResetCts", 32'(cts0), 32'd0);
    checkOutput("preResetIdle", 32'(idle0), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midRstSerial", 32'(serial0), 32'd1);
    checkOutput("midRstCts", 32'(cts0), 32'd1);
    checkOutput("midRstIdle", 32'(idle0), 32'd1);
    checkOutput("midRstSum", sum0, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(0, 1'b1, 8'h3C);
    tick();
    applyStimulus(0, 1'b0, 8'h00);
    waitIdle(0, 200);
    checkOutput("postRstSum", sum0, 32'h0000_003C);

    // Second instance: 7 clk/bit, 2 stop bits, 0xFF then 0x00 back-to-back.
    applyStimulus(1, 1'b1, 8'hFF);
    tick();
    data1 = 8'h00;
    tick();
    tick();
    req1 = 1'b0;
    for (int c = 3; c <= 78; c++) begin
      tick();
      if (c == 7)  checkOutput("sb2LastStart", 32'(serial1), 32'd0);
      if (c == 8)  checkOutput("sb2FirstData", 32'(serial1), 32'd1);
      if (c == 64) checkOutput("sb2Stop1", 32'(serial1), 32'd1);
      if (c == 77) checkOutput("sb2Stop2End", 32'(serial1), 32'd1);
      if (c == 77) checkOutput("sb2SumBefore", sum1, 32'd0);
      if (c == 78) checkOutput("sb2NextStart", 32'(serial1), 32'd0);
      if (c == 78) checkOutput("sb2SumFF", sum1, 32'h0000_00FF);
    end
    waitIdle(1, 300);
    checkOutput("sb2SumFinal", sum1, 32'h0000_00FF);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that sits directly upstream of the receiver in the UART test path. It accepts bytes over a valid/ready handshake into a one-entry holding register, then serialises them as 8N1 frames (optionally 8N2), LSB first, at `cycles_per_bit` clocks per bit. Its `o_serial` drives the receiver's `i_serial`. It keeps a running 32-bit sum of completed bytes, which the bench compares against the receiver's `o_sum`.

## Interface
- `cycles_per_bit`, default 4: clocks per serial bit. Must be ≥ 2.
- `stop_bits`, default 1: number of stop bits, 1 or 2.

- `clk`  in  1  the single clock; all state updates on posedge.
- `rst_n`  in  1  reset, asynchronous assert, active low; one clock, asynchronous active-low reset.
- `i_data`  in  8  byte to transmit; sampled only on an accepted handshake.
- `i_req`  in  1  request; a byte is accepted on a posedge where `i_req && o_cts`.
- `o_serial`  out  1  serial line; idle high.
- `o_cts`  out  1  clear-to-send; high when the holding register is empty.
- `o_idle`  out  1  high when the shifter is idle and the holding register is empty.
- `o_sum`  out  32  wrapping sum of all bytes whose frame has completed.

## Operation
- Storage:
  - holding register `hold[7:0]` plus `hold_full`;
  - shifter `shift[7:0]`;
  - bit counter;
  - cycle counter of width `$clog2(cycles_per_bit)`;
  - state;
  - `sum[31:0]`.
- States:
  - IDLE: line high.
  - START: line 0.
  - DATA: line = `shift[0]`.
  - STOP: line 1.
- Cycle counter:
  - Loaded with `cycles_per_bit-1` on entry to every bit.
  - Decrements each clock.
  - The bit ends on the clock where the counter is 0.
- Transitions (each taken at the end of a bit):
  - IDLE→START when `hold_full`: copy `hold` to `shift`, clear `hold_full`.
  - START→DATA: bit counter = 7.
  - DATA: shift `shift` right by 1 and decrement the bit counter; after bit counter 0, go to STOP with stop counter = `stop_bits-1`.
  - STOP end, last stop bit:
    - `sum <= sum + {24'b0, byte}` (mod 2^32); byte = the value sent.
    - If `hold_full`: go directly to START, loading `shift` from `hold` and clearing `hold_full`.
    - Otherwise go to IDLE.
- Handshake:
  - Acceptance sets `hold_full` and captures `i_data`.
  - `o_cts = !hold_full`, taken purely from registers.
  - `i_req` while `o_cts`=0 is ignored, and `i_data` is not sampled.
- Simultaneous events:
  - Holding drained on the same edge as `i_req` was presented: no accept, because `o_cts` was 0 during that cycle.
  - Accept in the final cycle of a STOP bit while `hold_full`=0: the byte lands in `hold`. The shifter goes to IDLE, then to START one clock later.
- Reset mid-frame, asynchronous:
  - `o_serial` returns to 1 immediately.
  - The frame is abandoned and the pending byte dropped.
  - The abandoned byte is not added to the sum.

## Timing
- Reset values:
  - `o_serial`=1, `o_cts`=1, `o_idle`=1, `o_sum`=0.
  - All internal registers 0; state IDLE.
- Latency: accept on edge E0 → START entered on E1 → `o_serial`=0 from E1 for `cycles_per_bit` clocks.
- Frame length: `(9+stop_bits)*cycles_per_bit` clocks.
  - Default: 40 clocks.
  - With `stop_bits`=2: 44 clocks.
- Back-to-back: when `hold_full` at the end of the last stop bit, the next start bit begins on the following clock with no idle gap.
- `o_sum` updates on the edge ending the last stop bit. The byte is visible there one clock after the final stop bit ends.
- `o_idle` goes high on the edge entering IDLE with `hold_full`=0.

## Test plan
- Reset then idle, 100 clocks with `i_req`=0 → `o_serial`=1, `o_cts`=1, `o_idle`=1, `o_sum`=0 throughout.
- Send 0xA5 (cycles_per_bit=4) → line pattern, 4 clocks each: 0, then 1,0,1,0,0,1,0,1, then 1. `o_sum`=0xA5 after 40 clocks. The receiver shows `o_data`=0xA5 and `o_valid` pulses.
- Stream 0x01, 0x02, …, 0x10 holding `i_req` high → each byte accepted exactly once, no idle gap between frames. Final `o_sum`=136 and receiver `o_sum`=136.
- `i_req` high with `o_cts`=0 while changing `i_data` each cycle → only bytes present on accept edges are sent.
- Assert `rst_n`=0 in the middle of data bit 3 of 0x5A → `o_serial`=1 immediately, `o_sum`=0, `o_cts`=1. After release the next byte 0x3C is sent cleanly.
- `stop_bits`=2, `cycles_per_bit`=7, bytes 0xFF then 0x00 → frames of 77 clocks each, stop high for 14 clocks, `o_sum`=0xFF.
